// File: rtl/mac_pkg.sv
// Shared types and default parameters for the multi-lane MAC engine.
package mac_pkg;

    // Per-element control that travels alongside the product pipeline.
    // One copy is shared by all lanes because every lane sees the same element.
    typedef struct packed {
        logic valid;  // element present
        logic clear;  // element starts a new dot product
        logic last;   // element ends the dot product
    } mac_ctl_t;

    localparam int DEF_INW         = 16;
    localparam int DEF_OUTW        = 48;
    localparam int DEF_LANES       = 4;
    localparam int DEF_MULT_STAGES = 2;

    // Saturation limits for an OUTW-bit two's complement accumulator:
    //   MAXVAL = 2^(OUTW-1) - 1  = {1'b0, {(OUTW-1){1'b1}}}
    //   MINVAL = -2^(OUTW-1)     = {1'b1, {(OUTW-1){1'b0}}}
    // They are built by bit replication inside mac_lane so they follow
    // whatever OUTW the instance is given, with no arithmetic overflow
    // at elaboration time.

endpackage

// File: rtl/mac_lane.sv
// One MAC lane: pipelined signed multiplier feeding a saturating accumulator
// with a sticky saturation flag.
module mac_lane
    import mac_pkg::*;
#(
    parameter int INW         = DEF_INW,
    parameter int OUTW        = DEF_OUTW,
    parameter int MULT_STAGES = DEF_MULT_STAGES
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [INW-1:0]  in0,
    input  logic [INW-1:0]  in1,
    input  logic            acc_en,
    input  logic            acc_clear,
    output logic [OUTW-1:0] acc,
    output logic            sat
);

    localparam int PW = 2 * INW;
    localparam logic signed [OUTW-1:0] MAXVAL = {1'b0, {(OUTW-1){1'b1}}};
    localparam logic signed [OUTW-1:0] MINVAL = {1'b1, {(OUTW-1){1'b0}}};

    logic signed [PW-1:0]   prod_d [MULT_STAGES];
    logic signed [PW-1:0]   prod_q [MULT_STAGES];
    logic signed [OUTW-1:0] acc_d, acc_q;
    logic                   sat_d, sat_q;
    logic signed [OUTW:0]   sum;

    // Full-width signed product enters the pipeline; later stages just shift.
    always_comb begin
        prod_d[0] = PW'($signed(in0)) * PW'($signed(in1));
        for (int s = 1; s < MULT_STAGES; s++) begin
            prod_d[s] = prod_q[s-1];
        end
    end

    // Product pipeline registers.
    // NOTE: the data stages are reset too so out never shows stale X-derived
    // values after reset; the control valid bits alone decide what is used.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int s = 0; s < MULT_STAGES; s++) begin
                prod_q[s] <= '0;
            end
        end else begin
            // NOTE: non-blocking so every stage samples its predecessor's old value.
            for (int s = 0; s < MULT_STAGES; s++) begin
                prod_q[s] <= prod_d[s];
            end
        end
    end

    // Accumulate with exact clamp: the sum is formed one bit wider and an
    // overflow shows up as disagreeing top two bits.
    always_comb begin
        // NOTE: hold values assigned first so no path leaves acc_d/sat_d unassigned (no latch).
        acc_d = acc_q;
        sat_d = sat_q;
        sum   = (OUTW+1)'(acc_q) + (OUTW+1)'(prod_q[MULT_STAGES-1]);
        if (acc_en) begin
            if (acc_clear) begin
                acc_d = OUTW'(prod_q[MULT_STAGES-1]);
                sat_d = 1'b0;
            end else if (sum[OUTW] != sum[OUTW-1]) begin
                acc_d = sum[OUTW] ? MINVAL : MAXVAL;
                sat_d = 1'b1;
            end else begin
                acc_d = sum[OUTW-1:0];
            end
        end
    end

    // Accumulator and sticky flag registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc_q <= '0;
            sat_q <= 1'b0;
        end else begin
            acc_q <= acc_d;
            sat_q <= sat_d;
        end
    end

    assign acc = acc_q;
    assign sat = sat_q;

endmodule

// File: rtl/mac_lanes.sv
// Multi-lane MAC engine: one shared control pipeline, LANES independent
// signed datapaths, single-cycle out_valid on each completed dot product.
// OUTW must be at least 2*INW and MULT_STAGES at least 1.
module mac_lanes
    import mac_pkg::*;
#(
    parameter int INW         = DEF_INW,
    parameter int OUTW        = DEF_OUTW,
    parameter int LANES       = DEF_LANES,
    parameter int MULT_STAGES = DEF_MULT_STAGES
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    input  logic                  in_clear,
    input  logic                  in_last,
    input  logic [LANES*INW-1:0]  in0,
    input  logic [LANES*INW-1:0]  in1,
    output logic [LANES*OUTW-1:0] out,
    output logic                  out_valid,
    output logic [LANES-1:0]      sat_flag
);

    mac_ctl_t ctl_d [MULT_STAGES];
    mac_ctl_t ctl_q [MULT_STAGES];
    logic     out_valid_d, out_valid_q;

    // Control shift register; flags are qualified by in_valid on entry so
    // bubbles carry no clear/last downstream.
    always_comb begin
        ctl_d[0] = '{valid: in_valid,
                     clear: in_valid & in_clear,
                     last:  in_valid & in_last};
        for (int s = 1; s < MULT_STAGES; s++) begin
            ctl_d[s] = ctl_q[s-1];
        end
        out_valid_d = ctl_q[MULT_STAGES-1].valid & ctl_q[MULT_STAGES-1].last;
    end

    // Control pipeline and out_valid registers; reset drops in-flight elements.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int s = 0; s < MULT_STAGES; s++) begin
                ctl_q[s] <= '0;
            end
            out_valid_q <= 1'b0;
        end else begin
            for (int s = 0; s < MULT_STAGES; s++) begin
                ctl_q[s] <= ctl_d[s];
            end
            out_valid_q <= out_valid_d;
        end
    end

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        mac_lane #(
            .INW         (INW),
            .OUTW        (OUTW),
            .MULT_STAGES (MULT_STAGES)
        ) u_lane (
            .clk       (clk),
            .reset     (reset),
            .in0       (in0[i*INW +: INW]),
            .in1       (in1[i*INW +: INW]),
            .acc_en    (ctl_q[MULT_STAGES-1].valid),
            .acc_clear (ctl_q[MULT_STAGES-1].clear),
            .acc       (out[i*OUTW +: OUTW]),
            .sat       (sat_flag[i])
        );
    end

    assign out_valid = out_valid_q;

endmodule
